// File: rtl/mips_state_sequencer.sv
// Multicycle MIPS instruction-phase sequencer.
// Classifies the current instruction, steps through the fetch/decode/execute/memory/write-back
// phases, stalls memory phases on waitrequest, counts retired instructions and halts when
// execution jumps to address 0.
module mips_state_sequencer #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func_code,
  input  logic               waitrequest,
  input  logic               pc_next_zero,
  output logic [2:0]         state,
  output logic               active,
  output logic               stall,
  output logic               retire,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteBack = 3'd4,
    StHalted    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsJmp,
    ClsRwb,
    ClsLd,
    ClsSt,
    ClsNop
  } class_e;

  localparam logic [5:0] FuncJr = 6'b001000;

  state_e               state_q, state_d;
  logic                 active_q, active_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  class_e               cls;
  logic                 mem_phase;

  // Instruction class from opcode/func_code.
  always_comb begin
    cls = ClsNop;
    if (opcode == 6'd0) begin
      cls = (func_code == FuncJr) ? ClsJmp : ClsRwb;
    end else if (opcode == 6'd3) begin
      cls = ClsRwb;  // JAL writes the link register
    end else if (opcode[5:3] == 3'b000) begin
      cls = ClsJmp;
    end else if (opcode[5:3] == 3'b001) begin
      cls = ClsRwb;
    end else if (opcode[5:3] == 3'b100) begin
      cls = ClsLd;
    end else if (opcode[5:3] == 3'b101) begin
      cls = ClsSt;
    end
  end

  assign mem_phase = (state_q == StFetch) || (state_q == StMemory);
  assign stall     = active_q && waitrequest && mem_phase;

  // Next phase, retire pulse and counter/active next state.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (active_q) begin
      unique case (state_q)
        StFetch: begin
          if (!waitrequest) state_d = StDecode;
        end
        StDecode: state_d = StExecute;
        StExecute: begin
          unique case (cls)
            ClsRwb:        state_d = StWriteBack;
            ClsLd, ClsSt:  state_d = StMemory;
            default:       retire  = 1'b1;
          endcase
        end
        StMemory: begin
          if (!waitrequest) begin
            if (cls == ClsLd) state_d = StWriteBack;
            else              retire  = 1'b1;
          end
        end
        StWriteBack: retire = 1'b1;
        StHalted:    state_d = StHalted;
        default:     state_d = StFetch;  // recover from unused encodings
      endcase
      if (retire) state_d = pc_next_zero ? StHalted : StFetch;
    end

    // Halt is sticky until reset; otherwise the CPU runs from the first post-reset edge.
    if (state_q == StHalted)          active_d = 1'b0;
    else if (retire && pc_next_zero)  active_d = 1'b0;
    else                              active_d = 1'b1;

    count_d = count_q + COUNT_W'(retire);
  end

  // State, active flag and retire counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      active_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  assign state       = state_q;
  assign active      = active_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_state_sequencer.sv
// Randomized self-checking bench for mips_state_sequencer.
// The reference model walks a per-class list of phases for each instruction.
module tb_mips_state_sequencer;

  localparam int unsigned CW = 4;  // small counter so wrap-around is exercised

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    func_code;
  logic          waitrequest;
  logic          pc_next_zero;
  logic [2:0]    state;
  logic          active;
  logic          stall;
  logic          retire;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int failures = 0;

  mips_state_sequencer #(.COUNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .func_code    (func_code),
    .waitrequest  (waitrequest),
    .pc_next_zero (pc_next_zero),
    .state        (state),
    .active       (active),
    .stall        (stall),
    .retire       (retire),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // 0: jump/nop (F,D,E)  1: reg write-back (F,D,E,W)  2: load (F,D,E,M,W)  3: store (F,D,E,M)
  function automatic int class_of(input int op, input int fn);
    if (op == 0)              return (fn == 8) ? 0 : 1;
    if (op == 3)              return 1;
    if (op < 8)               return 0;
    if (op < 16)              return 1;
    if (op >= 32 && op < 40)  return 2;
    if (op >= 40 && op < 48)  return 3;
    return 0;
  endfunction

  function automatic int len_of(input int cls);
    case (cls)
      0:       return 3;
      2:       return 5;
      default: return 4;
    endcase
  endfunction

  function automatic int phase_at(input int cls, input int idx);
    if (idx < 3)  return idx;
    if (idx == 4) return 4;
    return (cls == 1) ? 4 : 3;
  endfunction

  int m_cls, m_idx, m_count;
  bit m_active, m_halted, pend_new;

  task automatic new_instr();
    opcode    = 6'($urandom);
    func_code = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
    m_cls     = class_of(int'(opcode), int'(func_code));
  endtask

  initial begin
    int  exp_state;
    bit  hold, exp_stall, exp_retire;
    int  max_count;

    reset        = 1'b1;
    waitrequest  = 1'b0;
    pc_next_zero = 1'b0;
    new_instr();
    m_idx    = 0;
    m_count  = 0;
    m_active = 1'b0;
    m_halted = 1'b0;
    pend_new = 1'b0;
    max_count = 0;
    @(posedge clk);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (pend_new) begin
        new_instr();
        pend_new = 1'b0;
      end
      if (cyc < 3)        reset = 1'b1;
      else if (m_halted)  reset = ($urandom_range(0, 7) == 0);
      else                reset = ($urandom_range(0, 299) == 0);
      waitrequest  = ($urandom_range(0, 2) == 0);
      pc_next_zero = ($urandom_range(0, 24) == 0);
      #1;

      exp_state  = m_halted ? 5 : phase_at(m_cls, m_idx);
      hold       = ((exp_state == 0) || (exp_state == 3)) && waitrequest;
      exp_stall  = m_active && hold;
      exp_retire = m_active && !m_halted && !hold && (m_idx == len_of(m_cls) - 1);

      check_eq("state",       32'(state),       32'(exp_state));
      check_eq("active",      32'(active),      32'(m_active));
      check_eq("stall",       32'(stall),       32'(exp_stall));
      check_eq("retire",      32'(retire),      32'(exp_retire));
      check_eq("instr_count", 32'(instr_count), 32'(m_count));
      if (m_count > max_count) max_count = m_count;

      // Model update for the coming rising edge.
      if (reset) begin
        m_active = 1'b0;
        m_halted = 1'b0;
        m_count  = 0;
        m_idx    = 0;
        pend_new = 1'b1;
      end else if (m_halted) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
      end else if (exp_retire) begin
        m_count = (m_count + 1) % (1 << CW);
        m_idx   = 0;
        pend_new = 1'b1;
        if (pc_next_zero) begin
          m_halted = 1'b1;
          m_active = 1'b0;
        end
      end else if (!hold) begin
        m_idx++;
      end
      @(posedge clk);
    end

    // The counter must have reached its top value at least once for wrap to be meaningful.
    check_eq("count_reached_max", 32'(max_count), 32'((1 << CW) - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
